// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter_if : two read-command/response streams plus one write     |
// | stream sharing a single-port RAM.                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  wr_valid;
   logic                  wr_ready;
   logic [ADDR_WIDTH-1:0] wr_address;
   logic [DATA_WIDTH-1:0] wr_data;

   logic                  cmdA_valid;
   logic                  cmdA_ready;
   logic [ADDR_WIDTH-1:0] cmdA_payload;
   logic                  rspA_valid;
   logic                  rspA_ready;
   logic [DATA_WIDTH-1:0] rspA_payload;

   logic                  cmdB_valid;
   logic                  cmdB_ready;
   logic [ADDR_WIDTH-1:0] cmdB_payload;
   logic                  rspB_valid;
   logic                  rspB_ready;
   logic [DATA_WIDTH-1:0] rspB_payload;

   modport slave (
      input  wr_valid, wr_address, wr_data,
      input  cmdA_valid, cmdA_payload, rspA_ready,
      input  cmdB_valid, cmdB_payload, rspB_ready,
      output wr_ready, cmdA_ready, cmdB_ready,
      output rspA_valid, rspA_payload, rspB_valid, rspB_payload
   );

   modport master (
      output wr_valid, wr_address, wr_data,
      output cmdA_valid, cmdA_payload, rspA_ready,
      output cmdB_valid, cmdB_payload, rspB_ready,
      input  wr_ready, cmdA_ready, cmdB_ready,
      input  rspA_valid, rspA_payload, rspB_valid, rspB_payload
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter : round-robin (A -> B -> W) access to one single-port RAM |
// | with a one-entry response buffer per reader. Optional MEM_ARB_STATS_EN     |
// | adds saturating wait-cycle counters.                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  wire logic        clk,
   input  wire logic        reset,
`ifdef MEM_ARB_STATS_EN
   input  wire logic        stat_clear,
   output logic [15:0]      statA_wait,
   output logic [15:0]      statB_wait,
   output logic [15:0]      statW_wait,
`endif
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      SRC_A = 2'd0,
      SRC_B = 2'd1,
      SRC_W = 2'd2
   } src_t;

   localparam int c_DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

   src_t                  r_last_grant;
   src_t                  w_last_grant_nxt;

   logic                  w_elig_a;
   logic                  w_elig_b;
   logic                  w_elig_w;
   logic                  w_grant_a;
   logic                  w_grant_b;
   logic                  w_grant_w;

   logic                  r_rspA_valid;
   logic [DATA_WIDTH-1:0] r_rspA_payload;
   logic                  r_rspB_valid;
   logic [DATA_WIDTH-1:0] r_rspB_payload;

   // A reader is eligible only if its buffer is free or draining this cycle.
   assign w_elig_a = bus.cmdA_valid && (!r_rspA_valid || bus.rspA_ready);
   assign w_elig_b = bus.cmdB_valid && (!r_rspB_valid || bus.rspB_ready);
   assign w_elig_w = bus.wr_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_grant <= SRC_W;
      end else begin
         r_last_grant <= w_last_grant_nxt;
      end
   end

   always_comb begin
      w_grant_a        = 1'b0;
      w_grant_b        = 1'b0;
      w_grant_w        = 1'b0;
      w_last_grant_nxt = r_last_grant;
      case (r_last_grant)
         SRC_A: begin
            if (w_elig_b)      w_grant_b = 1'b1;
            else if (w_elig_w) w_grant_w = 1'b1;
            else if (w_elig_a) w_grant_a = 1'b1;
         end
         SRC_B: begin
            if (w_elig_w)      w_grant_w = 1'b1;
            else if (w_elig_a) w_grant_a = 1'b1;
            else if (w_elig_b) w_grant_b = 1'b1;
         end
         default: begin
            if (w_elig_a)      w_grant_a = 1'b1;
            else if (w_elig_b) w_grant_b = 1'b1;
            else if (w_elig_w) w_grant_w = 1'b1;
         end
      endcase
      if (w_grant_a)      w_last_grant_nxt = SRC_A;
      else if (w_grant_b) w_last_grant_nxt = SRC_B;
      else if (w_grant_w) w_last_grant_nxt = SRC_W;
   end

   assign bus.cmdA_ready = w_grant_a;
   assign bus.cmdB_ready = w_grant_b;
   assign bus.wr_ready   = w_grant_w;

   // RAM is not reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && w_grant_w) begin
         r_mem[bus.wr_address] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rspA_valid   <= 1'b0;
         r_rspA_payload <= '0;
         r_rspB_valid   <= 1'b0;
         r_rspB_payload <= '0;
      end else begin
         if (w_grant_a) begin
            r_rspA_valid   <= 1'b1;
            r_rspA_payload <= r_mem[bus.cmdA_payload];
         end else if (r_rspA_valid && bus.rspA_ready) begin
            r_rspA_valid <= 1'b0;
         end
         if (w_grant_b) begin
            r_rspB_valid   <= 1'b1;
            r_rspB_payload <= r_mem[bus.cmdB_payload];
         end else if (r_rspB_valid && bus.rspB_ready) begin
            r_rspB_valid <= 1'b0;
         end
      end
   end

   assign bus.rspA_valid   = r_rspA_valid;
   assign bus.rspA_payload = r_rspA_payload;
   assign bus.rspB_valid   = r_rspB_valid;
   assign bus.rspB_payload = r_rspB_payload;

`ifdef MEM_ARB_STATS_EN
   localparam logic [15:0] c_STAT_MAX = 16'hFFFF;

   logic [15:0] r_statA_wait;
   logic [15:0] r_statB_wait;
   logic [15:0] r_statW_wait;
   logic        w_wait_a;
   logic        w_wait_b;
   logic        w_wait_w;

   assign w_wait_a = bus.cmdA_valid && !w_grant_a;
   assign w_wait_b = bus.cmdB_valid && !w_grant_b;
   assign w_wait_w = bus.wr_valid   && !w_grant_w;

   // Clear wins over a coincident wait cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_statA_wait <= '0;
         r_statB_wait <= '0;
         r_statW_wait <= '0;
      end else if (stat_clear) begin
         r_statA_wait <= '0;
         r_statB_wait <= '0;
         r_statW_wait <= '0;
      end else begin
         if (w_wait_a && r_statA_wait != c_STAT_MAX) r_statA_wait <= r_statA_wait + 16'd1;
         if (w_wait_b && r_statB_wait != c_STAT_MAX) r_statB_wait <= r_statB_wait + 16'd1;
         if (w_wait_w && r_statW_wait != c_STAT_MAX) r_statW_wait <= r_statW_wait + 16'd1;
      end
   end

   assign statA_wait = r_statA_wait;
   assign statB_wait = r_statB_wait;
   assign statW_wait = r_statW_wait;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter : randomized and directed checks of mem_port_arbiter   |
// | against a round-robin reference model. Revision: 1.0                       |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
   logic        stat_clear;
   logic [15:0] statA_wait;
   logic [15:0] statB_wait;
   logic [15:0] statW_wait;
`endif

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef MEM_ARB_STATS_EN
      .stat_clear (stat_clear),
      .statA_wait (statA_wait),
      .statB_wait (statB_wait),
      .statW_wait (statW_wait),
`endif
      .bus        (bus)
   );

   // Reference model: source index 0=A, 1=B, 2=W; only addresses 0..31 are used.
   logic [DW-1:0] m_mem [32];
   bit            m_valid [2];
   logic [DW-1:0] m_data [2];
   int            m_last;
   int            m_wait [3];

   int err_count = 0;
   int chk_count = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_count++;
      if (act !== exp) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.wr_valid     = 1'b0;
      bus.wr_address   = '0;
      bus.wr_data      = '0;
      bus.cmdA_valid   = 1'b0;
      bus.cmdA_payload = '0;
      bus.rspA_ready   = 1'b1;
      bus.cmdB_valid   = 1'b0;
      bus.cmdB_payload = '0;
      bus.rspB_ready   = 1'b1;
`ifdef MEM_ARB_STATS_EN
      stat_clear       = 1'b0;
`endif
   endtask

   task automatic model_reset();
      m_valid[0] = 0; m_valid[1] = 0;
      m_data[0]  = '0; m_data[1] = '0;
      m_last     = 2;
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
   endtask

   // Inputs are already driven; check readies, clock once, check responses.
   task automatic step();
      bit            elig [3];
      bit            vld [3];
      bit            rdy [2];
      int            g;
      logic [4:0]    addr [3];
      logic [DW-1:0] wdata;
      bit            clr;
      #1;
      vld[0] = bus.cmdA_valid; vld[1] = bus.cmdB_valid; vld[2] = bus.wr_valid;
      rdy[0] = bus.rspA_ready; rdy[1] = bus.rspB_ready;
      addr[0] = bus.cmdA_payload[4:0]; addr[1] = bus.cmdB_payload[4:0];
      addr[2] = bus.wr_address[4:0];
      wdata   = bus.wr_data;
      clr = 0;
`ifdef MEM_ARB_STATS_EN
      clr = stat_clear;
`endif
      elig[0] = vld[0] && (!m_valid[0] || rdy[0]);
      elig[1] = vld[1] && (!m_valid[1] || rdy[1]);
      elig[2] = vld[2];
      g = -1;
      for (int k = 1; k <= 3; k++) begin
         if (g < 0 && elig[(m_last + k) % 3]) g = (m_last + k) % 3;
      end
      chk("cmdA_ready", 64'(bus.cmdA_ready), 64'(g == 0));
      chk("cmdB_ready", 64'(bus.cmdB_ready), 64'(g == 1));
      chk("wr_ready",   64'(bus.wr_ready),   64'(g == 2));
      @(posedge clk);
      for (int x = 0; x < 2; x++) begin
         if (g == x) begin
            m_valid[x] = 1;
            m_data[x]  = m_mem[addr[x]];
         end else if (m_valid[x] && rdy[x]) begin
            m_valid[x] = 0;
         end
      end
      if (g == 2) m_mem[addr[2]] = wdata;
      if (g >= 0) m_last = g;
      for (int s = 0; s < 3; s++) begin
         if (clr) m_wait[s] = 0;
         else if (vld[s] && g != s && m_wait[s] < 65535) m_wait[s]++;
      end
      #1;
      chk("rspA_valid",   64'(bus.rspA_valid),   64'(m_valid[0]));
      chk("rspA_payload", 64'(bus.rspA_payload), 64'(m_data[0]));
      chk("rspB_valid",   64'(bus.rspB_valid),   64'(m_valid[1]));
      chk("rspB_payload", 64'(bus.rspB_payload), 64'(m_data[1]));
`ifdef MEM_ARB_STATS_EN
      chk("statA_wait", 64'(statA_wait), 64'(m_wait[0]));
      chk("statB_wait", 64'(statB_wait), 64'(m_wait[1]));
      chk("statW_wait", 64'(statW_wait), 64'(m_wait[2]));
`endif
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset rspA_valid",   64'(bus.rspA_valid),   64'd0);
      chk("reset rspB_valid",   64'(bus.rspB_valid),   64'd0);
      chk("reset rspA_payload", 64'(bus.rspA_payload), 64'd0);
      chk("reset rspB_payload", 64'(bus.rspB_payload), 64'd0);
      reset = 1'b0;

      // Round robin with everything requesting: A, B, W, A, B, W.
      bus.cmdA_valid = 1; bus.cmdB_valid = 1; bus.wr_valid = 1;
      bus.cmdA_payload = 8'd20; bus.cmdB_payload = 8'd21;
      bus.wr_address = 8'd20; bus.wr_data = 32'h1111_2222;
      for (int i = 0; i < 6; i++) step();
      idle_inputs();

      // Preload addresses 0..31 through the write stream.
      for (int a = 0; a < 32; a++) begin
         bus.wr_valid = 1; bus.wr_address = AW'(a); bus.wr_data = $urandom;
         step();
      end

      // Write then read-after-write on address 0x10.
      bus.wr_valid = 1; bus.wr_address = 8'h10; bus.wr_data = 32'hDEAD_BEEF;
      step();
      idle_inputs();
      bus.cmdA_valid = 1; bus.cmdA_payload = 8'h10;
      step();
      chk("raw deadbeef", 64'(bus.rspA_payload), 64'h0000_0000_DEAD_BEEF);
      idle_inputs();
      step();

      // Reader A stalled: one grant, then held; B still served.
      bus.cmdA_valid = 1; bus.cmdA_payload = 8'd3; bus.rspA_ready = 0;
      for (int i = 0; i < 4; i++) step();
      bus.cmdB_valid = 1; bus.cmdB_payload = 8'd4;
      for (int i = 0; i < 4; i++) begin
         bus.cmdB_payload = AW'(i + 4);
         step();
      end
      idle_inputs();
      step();

      // Back-to-back streaming of addresses 0..7 on A.
      bus.cmdA_valid = 1;
      for (int i = 0; i < 8; i++) begin
         bus.cmdA_payload = AW'(i);
         step();
      end
      idle_inputs();
      step();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bus.cmdA_valid   = ($urandom_range(0, 3) != 0);
         bus.cmdB_valid   = ($urandom_range(0, 3) != 0);
         bus.wr_valid     = ($urandom_range(0, 2) == 0);
         bus.rspA_ready   = ($urandom_range(0, 2) != 0);
         bus.rspB_ready   = ($urandom_range(0, 2) != 0);
         bus.cmdA_payload = AW'($urandom_range(0, 31));
         bus.cmdB_payload = AW'($urandom_range(0, 31));
         bus.wr_address   = AW'($urandom_range(0, 31));
         bus.wr_data      = $urandom;
`ifdef MEM_ARB_STATS_EN
         stat_clear       = ($urandom_range(0, 49) == 0);
`endif
         step();
      end
      idle_inputs();
      step();

      // Reset while B holds a response and a write is pending.
      bus.cmdB_valid = 1; bus.cmdB_payload = 8'd9; bus.rspB_ready = 0;
      step();
      bus.cmdB_valid = 0;
      bus.wr_valid = 1; bus.wr_address = 8'd5; bus.wr_data = 32'hCAFE_F00D;
      reset = 1'b1;
      #1;
      chk("async rspB_valid", 64'(bus.rspB_valid), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      idle_inputs();
      bus.cmdA_valid = 1; bus.cmdA_payload = 8'd5;
      bus.cmdB_valid = 1; bus.cmdB_payload = 8'd6;
      bus.wr_valid = 1; bus.wr_address = 8'd7; bus.wr_data = 32'h0BAD_0BAD;
      #1;
      chk("A first after reset", 64'(bus.cmdA_ready), 64'd1);
      step();
      for (int i = 0; i < 3; i++) step();
      idle_inputs();
      step();

`ifdef MEM_ARB_STATS_EN
      // Saturation: A held stalled for 70000 cycles, then cleared.
      bus.cmdA_valid = 1; bus.cmdA_payload = 8'd1; bus.rspA_ready = 0;
      step();
      repeat (70000) begin
         @(posedge clk);
         if (m_wait[0] < 65535) m_wait[0]++;
      end
      #1;
      chk("statA saturated", 64'(statA_wait), 64'hFFFF);
      stat_clear = 1;
      step();
      stat_clear = 0;
      chk("statA cleared", 64'(statA_wait), 64'd0);
      idle_inputs();
      step();
`endif

      $display("Result: errors=%0d of %0d checks", err_count, chk_count);
      $finish;
   end
endmodule
`default_nettype wire
